// File: rtl/branch_unit_pkg.sv
// Shared cpu definitions for the branch unit: condition codes, flag bit
// positions and branch FSM state encoding.
package branch_unit_pkg;

   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [2:0] {
      COND_NE = 3'b000,
      COND_EQ = 3'b001,
      COND_GT = 3'b010,
      COND_LT = 3'b011,
      COND_GE = 3'b100,
      COND_LE = 3'b101,
      COND_OV = 3'b110,
      COND_AL = 3'b111
   } cond_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } bu_state_e;

endpackage

// File: rtl/branch_unit_cond_eval.sv
// Branch condition evaluator: decides whether a condition code passes
// for a given {N,Z,V} flag vector.
module cond_eval
   import branch_unit_pkg::*;
(
   input  logic [2:0] flags,
   input  logic [2:0] cond,
   output logic       pass
);

   logic n, z, v;

   always_comb begin
      n = flags[FLAG_N];
      z = flags[FLAG_Z];
      v = flags[FLAG_V];
      pass = 1'b0;
      case (cond_e'(cond))
         COND_NE: pass = ~z;
         COND_EQ: pass = z;
         COND_GT: pass = ~z & ~n;
         COND_LT: pass = n;
         COND_GE: pass = z | ~n;
         COND_LE: pass = n | z;
         COND_OV: pass = v;
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution in decode: flag register, target generation and a
// one-cycle flag-hazard stall FSM (bypassed when FLAG_FWD_EN is defined).
module branch_unit
   import branch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        branch,
   input  logic        branch_src,
   input  logic [2:0]  cond,
   input  logic [8:0]  imm9,
   input  logic [15:0] pc_plus2,
   input  logic [15:0] rs_data,
   input  logic [2:0]  ex_flag_we,
   input  logic        ex_n,
   input  logic        ex_z,
   input  logic        ex_v,
   input  logic        ext_stall,
   output logic        taken,
   output logic [15:0] target,
   output logic        flush_ifid,
   output logic        stall_id,
   output logic [2:0]  flags
);

   logic [2:0]  flags_q, flags_d;
   logic [2:0]  merged_flags;
   logic [2:0]  eval_flags;
   logic [15:0] imm_off;
   logic        hazard;
   logic        pass;
   bu_state_e   state_q, state_d;

   always_comb begin
      merged_flags = (flags_q & ~ex_flag_we) | ({ex_n, ex_z, ex_v} & ex_flag_we);
      flags_d      = ext_stall ? flags_q : merged_flags;
`ifdef FLAG_FWD_EN
      eval_flags = merged_flags;
      hazard     = 1'b0;
`else
      eval_flags = flags_q;
      hazard     = branch & (cond_e'(cond) != COND_AL) & (|ex_flag_we);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
         state_q <= ST_IDLE;
      end else begin
         flags_q <= flags_d;
         state_q <= state_d;
      end
   end

   cond_eval u_cond_eval (
      .flags (eval_flags),
      .cond  (cond),
      .pass  (pass)
   );

   // Offset is a word count; shift left one to get a byte offset.
   always_comb begin
      imm_off = {{6{imm9[8]}}, imm9, 1'b0};
      target  = branch_src ? rs_data : (pc_plus2 + imm_off);
   end

   // In WAIT the flags register already holds the EX result, so no re-check.
   always_comb begin
      state_d  = state_q;
      taken    = 1'b0;
      stall_id = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hazard) begin
               stall_id = 1'b1;
               if (!ext_stall) state_d = ST_WAIT;
            end else begin
               taken = branch & pass & ~ext_stall;
            end
         end
         ST_WAIT: begin
            if (!ext_stall) begin
               taken   = branch & pass;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (rst) begin
         taken    = 1'b0;
         stall_id = 1'b0;
      end
   end

   assign flush_ifid = taken;
   assign flags      = flags_q;

endmodule
